// File: rtl/split_stim_driver.sv
// Random stimulus driver for a split constraint checker: builds VEC_W-bit vectors from a
// 32-bit LFSR, holds each one until the checker answers, and tallies sat/unsat results.
// Optional macro SPLIT_DRV_FAILCAP_EN adds fail_vec/fail_seen capture of the first failing vector.
//
// Handshake: vec_valid rises when a fully built vector is on vec_out and stays high (vec_out
// frozen) until a res_valid is sampled; that edge consumes the result and vec_valid drops.
module split_stim_driver #(
    parameter int VEC_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_vec,
    output logic [VEC_W-1:0] vec_out,
    output logic             vec_valid,
    input  logic             res_valid,
    input  logic             res_sat,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sat_cnt,
    output logic [CNT_W-1:0] unsat_cnt,
`ifdef SPLIT_DRV_FAILCAP_EN
    output logic [VEC_W-1:0] fail_vec,
    output logic             fail_seen,
`endif
    output logic [1:0]       state_dbg
);

    localparam int WORDS = VEC_W / 32;
    localparam int FW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRIVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [31:0]      lfsr, lfsr_n;
    logic [FW-1:0]    fill_cnt;
    logic [CNT_W-1:0] issue_cnt, issue_inc;
    logic [CNT_W-1:0] num_vec_q;
    logic [VEC_W-1:0] vec_shift;
    logic             accept_start;
    logic             res_take;
    logic             fill_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Fibonacci LFSR, taps 32,22,2,1 (bits 31,21,1,0)
    assign lfsr_n = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

    generate
        if (WORDS == 1) begin : g_one_word
            assign vec_shift = lfsr_n;
        end else begin : g_multi_word
            assign vec_shift = {vec_out[VEC_W-33:0], lfsr_n};
        end
    endgenerate

    assign accept_start = start && !abort && (state == IDLE || state == DONE);
    assign res_take     = (state == DRIVE) && res_valid;
    assign fill_last    = (fill_cnt == FW'(WORDS - 1));
    assign issue_inc    = sat_inc(issue_cnt);

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (accept_start)
                    state_n = (num_vec == '0) ? DONE : FILL;
            end
            FILL: begin
                if (abort)
                    state_n = DONE;
                else if (fill_last)
                    state_n = DRIVE;
            end
            DRIVE: begin
                if (abort)
                    state_n = DONE;
                else if (res_valid)
                    state_n = (issue_inc == num_vec_q) ? DONE : FILL;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= '0;
            vec_out   <= '0;
            fill_cnt  <= '0;
            issue_cnt <= '0;
            num_vec_q <= '0;
            sat_cnt   <= '0;
            unsat_cnt <= '0;
`ifdef SPLIT_DRV_FAILCAP_EN
            fail_vec  <= '0;
            fail_seen <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept_start) begin
                lfsr      <= (seed == 32'h0) ? 32'h0000_0001 : seed;
                fill_cnt  <= '0;
                issue_cnt <= '0;
                num_vec_q <= num_vec;
                sat_cnt   <= '0;
                unsat_cnt <= '0;
`ifdef SPLIT_DRV_FAILCAP_EN
                fail_vec  <= '0;
                fail_seen <= 1'b0;
`endif
            end
            if (state == FILL && !abort) begin
                lfsr     <= lfsr_n;
                vec_out  <= vec_shift;
                fill_cnt <= fill_last ? '0 : fill_cnt + FW'(1);
            end
            // a result that lands together with abort is still tallied
            if (res_take) begin
                issue_cnt <= issue_inc;
                if (res_sat)
                    sat_cnt <= sat_inc(sat_cnt);
                else
                    unsat_cnt <= sat_inc(unsat_cnt);
`ifdef SPLIT_DRV_FAILCAP_EN
                if (!res_sat && !fail_seen) begin
                    fail_vec  <= vec_out;
                    fail_seen <= 1'b1;
                end
`endif
            end
        end
    end

    assign vec_valid = (state == DRIVE);
    assign busy      = (state == FILL) || (state == DRIVE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_split_stim_driver.sv
// Bench for split_stim_driver: vectors are predicted from the LFSR polynomial and seed rule,
// counters from the result pattern; a negedge compare process checks the DUT every cycle.
module tb_split_stim_driver;

    localparam int VEC_W = 64;
    localparam int CNT_W = 16;
    localparam int WORDS = VEC_W / 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, abort, res_valid, res_sat;
    logic [31:0]      seed;
    logic [CNT_W-1:0] num_vec;
    logic [VEC_W-1:0] vec_out;
    logic             vec_valid, busy, done;
    logic [CNT_W-1:0] sat_cnt, unsat_cnt;
    logic [1:0]       state_dbg;
`ifdef SPLIT_DRV_FAILCAP_EN
    logic [VEC_W-1:0] fail_vec;
    logic             fail_seen;
`endif

    split_stim_driver #(.VEC_W(VEC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .num_vec(num_vec), .vec_out(vec_out), .vec_valid(vec_valid),
        .res_valid(res_valid), .res_sat(res_sat), .busy(busy), .done(done),
        .sat_cnt(sat_cnt), .unsat_cnt(unsat_cnt),
`ifdef SPLIT_DRV_FAILCAP_EN
        .fail_vec(fail_vec), .fail_seen(fail_seen),
`endif
        .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // model state
    logic [VEC_W-1:0] exp_q[$];
    int               m_sat, m_unsat;
    logic [VEC_W-1:0] m_fail_vec;
    bit               m_fail_seen;
    bit               model_live = 1'b0;
    logic [VEC_W-1:0] first_seen, second_seen;

    int n_checks = 0;
    int miscompares = 0;
    int vectors_applied = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [VEC_W-1:0] nth_vec(input logic [31:0] sd, input int k);
        logic [31:0]      s;
        logic [VEC_W-1:0] v;
        s = (sd == 32'h0) ? 32'h1 : sd;
        v = '0;
        for (int i = 0; i <= k; i++) begin
            v = '0;
            for (int w = 0; w < WORDS; w++) begin
                s = lfsr_next(s);
                v = {v[VEC_W-33:0], s};
            end
        end
        return v;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_sat = 0;
        m_unsat = 0;
        m_fail_vec = '0;
        m_fail_seen = 1'b0;
    endtask

    task automatic model_result(input logic sat);
        if (!sat && !m_fail_seen) begin
            m_fail_seen = 1'b1;
            m_fail_vec = exp_q[0];
        end
        if (sat) m_sat++;
        else m_unsat++;
        void'(exp_q.pop_front());
    endtask

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            check("sat_cnt", 64'(sat_cnt), 64'(m_sat));
            check("unsat_cnt", 64'(unsat_cnt), 64'(m_unsat));
            if (vec_valid) begin
                check("busy_in_drive", 64'(busy), 64'd1);
                if (exp_q.size() == 0)
                    check("vec_valid_unexpected", 64'(vec_valid), 64'd0);
                else
                    check("vec_out", vec_out, exp_q[0]);
            end
`ifdef SPLIT_DRV_FAILCAP_EN
            check("fail_seen", 64'(fail_seen), 64'(m_fail_seen));
            check("fail_vec", fail_vec, m_fail_vec);
`endif
        end
    end

    // driver: one run; abort_idx < 0 means no abort
    task automatic do_run(input logic [31:0] sd, input int n, input logic [31:0] pat,
                          input int lat_max, input int abort_idx, input bit abort_res,
                          input bit glitch);
        int c;
        int lat;
        bit hit;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(nth_vec(sd, k));
        seed = sd;
        num_vec = CNT_W'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_sat = 0; m_unsat = 0; m_fail_seen = 1'b0; m_fail_vec = '0;
        if (n == 0) begin
            check("zero_run_done", 64'(done), 64'd1);
            check("zero_run_busy", 64'(busy), 64'd0);
            check("zero_run_valid", 64'(vec_valid), 64'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            hit = 1'b0;
            c = 0;
            while (c < 20 && !hit) begin
                res_valid = 1'($urandom_range(0, 1));
                res_sat = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                res_valid = 1'b0;
                c++;
                hit = vec_valid;
            end
            if (!hit) begin
                check("fill_timeout", 64'(vec_valid), 64'd1);
                return;
            end
            check("fill_len", 64'(c), 64'(WORDS));
            if (i == 0) first_seen = vec_out;
            if (i == 1) second_seen = vec_out;
            lat = (glitch && i == 1) ? 2 : $urandom_range(0, lat_max);
            repeat (lat) begin
                if (glitch && i == 1) begin
                    start = 1'b1;
                    seed = $urandom;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            res_sat = pat[i];
            if (i == abort_idx) begin
                abort = 1'b1;
                res_valid = abort_res;
                @(posedge clk); #1;
                abort = 1'b0;
                res_valid = 1'b0;
                if (abort_res) model_result(pat[i]);
                exp_q.delete();
                check("abort_done", 64'(done), 64'd1);
                check("abort_valid", 64'(vec_valid), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                return;
            end
            res_valid = 1'b1;
            @(posedge clk); #1;
            res_valid = 1'b0;
            model_result(pat[i]);
            vectors_applied++;
        end
        check("run_done", 64'(done), 64'd1);
        check("run_busy", 64'(busy), 64'd0);
        check("run_valid", 64'(vec_valid), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec_out"}, vec_out, 64'd0);
        check({tag, "_vec_valid"}, 64'(vec_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_sat"}, 64'(sat_cnt), 64'd0);
        check({tag, "_unsat"}, 64'(unsat_cnt), 64'd0);
    endtask

    initial begin
        logic [31:0] pat;
        int n;
        start = 1'b0; abort = 1'b0; res_valid = 1'b0; res_sat = 1'b0;
        seed = '0; num_vec = '0;
        model_clear();
        rst_n = 1'b0;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_live = 1'b1;

        // model pins for seed 1: words 3,6 then 0xD,0x1B
        check("model_vec0", nth_vec(32'h1, 0), 64'h0000_0003_0000_0006);
        check("model_vec1", nth_vec(32'h1, 1), 64'h0000_000D_0000_001B);

        // scenario 1: seed 1, three vectors, all satisfied after 2 cycles
        do_run(32'h1, 3, 32'h7, 2, -1, 1'b0, 1'b0);
        check("s1_first_vec", first_seen, 64'h0000_0003_0000_0006);
        check("s1_second_vec", second_seen, 64'h0000_000D_0000_001B);
        check("s1_sat", 64'(sat_cnt), 64'd3);
        check("s1_unsat", 64'(unsat_cnt), 64'd0);

        // results and abort outside a run change nothing
        repeat (3) begin
            res_valid = 1'b1; res_sat = 1'($urandom_range(0, 1)); abort = 1'b1;
            @(posedge clk); #1;
        end
        res_valid = 1'b0; abort = 1'b0;
        check("idle_abort_done", 64'(done), 64'd1);

        // scenario 2: seed 0 behaves as seed 1
        do_run(32'h0, 2, 32'h3, 3, -1, 1'b0, 1'b0);
        check("s2_first_vec", first_seen, 64'h0000_0003_0000_0006);

        // scenario 3: empty run
        do_run(32'h1234_5678, 0, 32'h0, 0, -1, 1'b0, 1'b0);

        // scenario 4: 1,0,0 pattern
        do_run(32'h1, 3, 32'h1, 3, -1, 1'b0, 1'b0);
        check("s4_sat", 64'(sat_cnt), 64'd1);
        check("s4_unsat", 64'(unsat_cnt), 64'd2);
`ifdef SPLIT_DRV_FAILCAP_EN
        check("s4_fail_vec", fail_vec, 64'h0000_000D_0000_001B);
        check("s4_fail_seen", 64'(fail_seen), 64'd1);
`endif

        // scenario 5: abort in DRIVE of vector 2, without and with a coincident result
        do_run(32'hACE1_0001, 5, 32'h1F, 2, 1, 1'b0, 1'b0);
        check("s5_sum", 64'(sat_cnt + unsat_cnt), 64'd1);
        do_run(32'hACE1_0001, 5, 32'h1D, 2, 1, 1'b1, 1'b0);
        check("s5_sum_res", 64'(sat_cnt + unsat_cnt), 64'd2);

        // scenario 6: reset mid-FILL, then ignored start while busy
        seed = 32'h5A5A_0003; num_vec = CNT_W'(4); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_all_zero("post_reset");
        end
        do_run(32'h0BAD_F00D, 4, 32'h5, 2, -1, 1'b0, 1'b1);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 6);
            pat = $urandom;
            if (r % 3 == 2)
                do_run($urandom, n, pat, 4, $urandom_range(0, n - 1), 1'($urandom_range(0, 1)), 1'b0);
            else
                do_run($urandom, n, pat, 4, -1, 1'b0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
